// File: rtl/uart_frame_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : uart_frame_sched_if                                            |
// | Purpose : FIFO read side and UART transmit side of the frame scheduler.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface uart_frame_sched_if;
    logic        fifo_empty;
    logic [15:0] fifo_q;
    logic        fifo_rdreq;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_wr_en;

    // master: the scheduler; slave: the FIFO/UART environment around it
    modport master (
        input  fifo_empty, fifo_q, tx_busy,
        output fifo_rdreq, tx_data, tx_wr_en
    );

    modport slave (
        output fifo_empty, fifo_q, tx_busy,
        input  fifo_rdreq, tx_data, tx_wr_en
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : uart_frame_sched                                               |
// | Purpose : Turns each 16-bit FIFO word into a 4-byte UART frame           |
// |           (header, high, low, XOR checksum) with a write-ack timeout.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_frame_sched #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  wire logic          clk_50m,
    input  wire logic          rst_n,
    input  wire logic          enable,
    input  wire logic          err_clr,
    uart_frame_sched_if.master bus,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic               err
);

    localparam int unsigned           c_ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_ACK_W-1:0]    c_ACK_LAST = c_ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD        = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic [15:0]          r_word;
    logic [1:0]           r_byte_idx;
    logic [c_ACK_W-1:0]   r_ack_cnt;
    logic [7:0]           r_tx_data;
    logic                 r_tx_wr_en;
    logic [15:0]          r_frame_cnt;
    logic                 r_err;

    logic                 w_start;
    logic                 w_timeout;
    logic [7:0]           w_checksum;
    logic [7:0]           w_tx_byte;

    // The read strobe is decoded in IDLE so the FIFO's one-cycle read latency
    // lands the word on fifo_q exactly during RD, and so the strobe can never
    // follow a stale fifo_empty. It is gated by rst_n to stay low in reset.
    assign w_start         = (r_state == S_IDLE) && enable && !bus.fifo_empty;
    assign bus.fifo_rdreq  = w_start && rst_n;

    assign w_timeout = (r_state == S_WAIT_ACK) && !bus.tx_busy && (r_ack_cnt == c_ACK_LAST);

    always_comb begin
        w_checksum = HEADER ^ r_word[15:8] ^ r_word[7:0];
        case (r_byte_idx)
            2'd0:    w_tx_byte = HEADER;
            2'd1:    w_tx_byte = r_word[15:8];
            2'd2:    w_tx_byte = r_word[7:0];
            default: w_tx_byte = w_checksum;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_word      <= 16'h0000;
            r_byte_idx  <= 2'd0;
            r_ack_cnt   <= '0;
            r_tx_data   <= 8'h00;
            r_tx_wr_en  <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_tx_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_RD;
                    end
                end

                S_RD: begin
                    r_word     <= bus.fifo_q;
                    r_byte_idx <= 2'd0;
                    r_state    <= S_SEND;
                end

                S_SEND: begin
                    if (!bus.tx_busy) begin
                        r_tx_data  <= w_tx_byte;
                        r_tx_wr_en <= 1'b1;
                        r_ack_cnt  <= '0;
                        r_state    <= S_WAIT_ACK;
                    end
                end

                // Busy seen on the last allowed cycle still counts as an ack.
                S_WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_ack_cnt == c_ACK_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr wins so no fault is ever lost.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_wr_en = r_tx_wr_en;
    assign busy         = (r_state != S_IDLE);
    assign frame_cnt    = r_frame_cnt;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_frame_sched                                            |
// | Purpose : Self-checking bench with FIFO/UART models and a frame model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_frame_sched;

    localparam logic [7:0] c_HDR = 8'hA5;
    localparam int         c_TMO = 16;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        err_clr;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;

    uart_frame_sched_if bus();

    uart_frame_sched #(.HEADER(c_HDR), .ACK_TIMEOUT(c_TMO)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .enable    (enable),
        .err_clr   (err_clr),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    always #10 clk_50m = ~clk_50m;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: words written by the stimulus, read pointer owned here
    logic [15:0] words [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_count = 0;
    int          viol_rd_empty = 0;
    logic [15:0] fifo_q_r = 16'h0000;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_q     = fifo_q_r;

    always @(posedge clk_50m) begin
        if (bus.fifo_rdreq) begin
            rd_count++;
            if (rd_ptr == wr_ptr) viol_rd_empty++;
            else begin
                fifo_q_r <= words[rd_ptr % 256];
                rd_ptr   <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [15:0] w);
        words[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    // UART model: logs written bytes, acks after a delay, stays busy a while
    int         ack_delay = 1;
    int         busy_len  = 10;
    bit         uart_dead = 1'b0;
    bit         rand_uart = 1'b0;
    int         rise_in = 0;
    int         hold = 0;
    int         d_now, len_now;
    int         log_n = 0;
    int         viol_wr_busy = 0;
    logic [7:0] tx_log [1024];
    logic       uart_busy = 1'b0;

    assign bus.tx_busy = uart_busy;

    always @(posedge clk_50m) begin
        if (bus.tx_wr_en) begin
            if (bus.tx_busy) viol_wr_busy++;
            tx_log[log_n % 1024] = bus.tx_data;
            log_n++;
            if (!uart_dead) begin
                d_now   = rand_uart ? int'($urandom_range(0, 8)) : ack_delay;
                len_now = rand_uart ? int'($urandom_range(1, 12)) : busy_len;
                if (d_now == 0) begin
                    uart_busy <= 1'b1;
                    hold = len_now;
                end else begin
                    rise_in = d_now;
                end
            end
        end else if (rise_in > 0) begin
            rise_in--;
            if (rise_in == 0) begin
                uart_busy <= 1'b1;
                hold = len_now;
            end
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) uart_busy <= 1'b0;
        end
    end

    // Protocol monitor on the sampling edge
    logic        prev_rd = 1'b0;
    logic [15:0] prev_fc = 16'h0000;
    int          viol_rd_busy = 0, viol_rd_long = 0, b2b_seen = 0, b2b_bad = 0;

    always @(negedge clk_50m) begin
        if (bus.fifo_rdreq && busy) viol_rd_busy++;
        if (bus.fifo_rdreq && prev_rd) viol_rd_long++;
        if (rst_n && enable && !bus.fifo_empty && frame_cnt == prev_fc + 16'd1) begin
            b2b_seen++;
            if (!bus.fifo_rdreq) b2b_bad++;
        end
        prev_rd = bus.fifo_rdreq;
        prev_fc = frame_cnt;
    end

    // Reference frame model: plain byte list per word
    logic [7:0] exp_q [$];

    function automatic void add_frame(input logic [15:0] w);
        logic [7:0] hi, lo;
        hi = w[15:8];
        lo = w[7:0];
        exp_q.push_back(c_HDR);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        exp_q.push_back(c_HDR ^ hi ^ lo);
    endfunction

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        @(negedge clk_50m);
        while (!(bus.fifo_empty && !busy && !uart_busy && rise_in == 0) && n < 4000) begin
            @(negedge clk_50m);
            n++;
        end
        check({name, "_done"}, 32'(n < 4000), 1);
        repeat (2) @(negedge clk_50m);
    endtask

    task automatic wait_log(input int target, input string name);
        int n;
        n = 0;
        while (log_n < target && n < 2000) begin
            @(negedge clk_50m);
            n++;
        end
        check({name, "_reached"}, 32'(log_n >= target), 1);
    endtask

    task automatic check_exp(input string name, input int base);
        check({name, "_nbytes"}, log_n - base, exp_q.size());
        for (int k = 0; k < exp_q.size() && k < log_n - base; k++)
            check($sformatf("%s_byte%0d", name, k), tx_log[(base + k) % 1024], exp_q[k]);
    endtask

    typedef struct {
        logic [15:0] word;
        int          ack_d;
        int          blen;
        int          exp_n;
        logic [31:0] exp_bytes;
        logic        exp_err;
        int          exp_inc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, rc0, n, lat;
        logic [15:0] fc0, dfc, w;
        logic [31:0] eb;

        vecs[0] = '{16'h0000, 1, 3, 4, 32'hA50000A5, 1'b0, 1};
        vecs[1] = '{16'hFFFF, 0, 1, 4, 32'hA5FFFFA5, 1'b0, 1};
        vecs[2] = '{16'hA55A, 3, 7, 4, 32'hA5A55A5A, 1'b0, 1};
        vecs[3] = '{16'h00A5, 2, 12, 4, 32'hA500A500, 1'b0, 1};
        vecs[4] = '{16'h1357, 14, 2, 4, 32'hA51357E1, 1'b0, 1};
        vecs[5] = '{16'hBEEF, 15, 2, 1, 32'hA5000000, 1'b1, 0};
        vecs[6] = '{16'hC3C3, 5, 4, 4, 32'hA5C3C3A5, 1'b0, 1};

        rst_n = 1'b0; enable = 1'b1; err_clr = 1'b0;
        push(16'h1234);
        repeat (3) @(negedge clk_50m);
        check("rst_rdreq", bus.fifo_rdreq, 0);
        check("rst_wr_en", bus.tx_wr_en, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err", err, 0);

        // Single word with a 10-cycle UART
        base = log_n; rc0 = rd_count;
        rst_n = 1'b1;
        exp_q.delete(); add_frame(16'h1234);
        wait_quiet("one_word");
        check_exp("one_word", base);
        check("one_word_fc", frame_cnt, 1);
        check("one_word_rd", rd_count - rc0, 1);

        // Table-driven single frames, including the ack-timeout boundary
        for (int i = 0; i < 7; i++) begin
            ack_delay = vecs[i].ack_d; busy_len = vecs[i].blen;
            base = log_n; fc0 = frame_cnt; rc0 = rd_count;
            push(vecs[i].word);
            wait_quiet($sformatf("vec%0d", i));
            eb = vecs[i].exp_bytes;
            check($sformatf("vec%0d_nbytes", i), log_n - base, vecs[i].exp_n);
            for (int k = 0; k < vecs[i].exp_n && k < log_n - base; k++)
                check($sformatf("vec%0d_byte%0d", i, k), tx_log[(base + k) % 1024], eb[31 - 8*k -: 8]);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            dfc = frame_cnt - fc0;
            check($sformatf("vec%0d_fc_inc", i), dfc, vecs[i].exp_inc);
            check($sformatf("vec%0d_rd", i), rd_count - rc0, 1);
            if (err) begin
                err_clr = 1'b1; @(negedge clk_50m); err_clr = 1'b0;
                check($sformatf("vec%0d_err_clr", i), err, 0);
            end
        end

        // Dead UART: err rises on the 16th WAIT_ACK cycle
        uart_dead = 1'b1; ack_delay = 1; busy_len = 10;
        base = log_n; fc0 = frame_cnt;
        push(16'h2468);
        n = 0;
        while (!bus.tx_wr_en && n < 100) begin @(negedge clk_50m); n++; end
        check("tmo_wr_seen", bus.tx_wr_en, 1);
        lat = 0;
        while (!err && lat < 40) begin @(negedge clk_50m); lat++; end
        check("tmo_latency", lat, c_TMO);
        check("tmo_busy", busy, 0);
        check("tmo_fc", frame_cnt, fc0);
        check("tmo_nbytes", log_n - base, 1);
        err_clr = 1'b1; @(negedge clk_50m); err_clr = 1'b0;
        check("tmo_err_clr", err, 0);

        // err_clr held through a second timeout: the timeout must win
        err_clr = 1'b1;
        push(16'h1357);
        n = 0;
        while (!bus.tx_wr_en && n < 100) begin @(negedge clk_50m); n++; end
        lat = 0;
        while (!err && lat < 40) begin @(negedge clk_50m); lat++; end
        check("tmo2_latency", lat, c_TMO);
        err_clr = 1'b0;
        @(negedge clk_50m);
        check("tmo2_err_sticky", err, 1);
        uart_dead = 1'b0;
        repeat (5) @(negedge clk_50m);

        // Async reset while waiting on byte 2; partial frame is dropped
        base = log_n;
        push(16'hCAFE); push(16'h5678);
        wait_log(base + 2, "rst_mid");
        n = 0;
        while (!uart_busy && n < 50) begin @(negedge clk_50m); n++; end
        repeat (2) @(negedge clk_50m);
        check("rst_mid_tx_hold", bus.tx_data, 8'hCA);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_rdreq", bus.fifo_rdreq, 0);
        check("rst_mid_wr_en", bus.tx_wr_en, 0);
        check("rst_mid_tx_data", bus.tx_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_fc", frame_cnt, 0);
        check("rst_mid_err", err, 0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        base = log_n;
        exp_q.delete(); add_frame(16'h5678);
        wait_quiet("rst_after");
        check_exp("rst_after", base);
        check("rst_after_fc", frame_cnt, 1);

        // enable dropped after byte 2: frame finishes, no new read
        base = log_n; rc0 = rd_count; fc0 = frame_cnt;
        push(16'h0F0F); push(16'h1111);
        wait_log(base + 2, "en_drop");
        enable = 1'b0;
        n = 0;
        while ((busy || uart_busy || rise_in != 0) && n < 2000) begin @(negedge clk_50m); n++; end
        repeat (30) @(negedge clk_50m);
        exp_q.delete(); add_frame(16'h0F0F);
        check_exp("en_drop", base);
        dfc = frame_cnt - fc0;
        check("en_drop_fc_inc", dfc, 1);
        check("en_drop_rd", rd_count - rc0, 1);
        check("en_drop_fifo_kept", bus.fifo_empty, 0);
        enable = 1'b1;
        add_frame(16'h1111);
        wait_quiet("en_resume");
        check_exp("en_resume", base);
        check("en_resume_rd", rd_count - rc0, 2);

        // frame_cnt wrap
        @(negedge clk_50m);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk_50m);
        release dut.r_frame_cnt;
        @(negedge clk_50m);
        check("wrap_preload", frame_cnt, 16'hFFFF);
        push(16'h4242);
        wait_quiet("wrap");
        check("wrap_fc", frame_cnt, 16'h0000);

        // Randomized bursts against the frame model
        rand_uart = 1'b1;
        for (int r = 0; r < 5; r++) begin
            base = log_n; fc0 = frame_cnt;
            exp_q.delete();
            n = (r == 0) ? 3 : int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++) begin
                w = 16'($urandom);
                push(w);
                add_frame(w);
            end
            if (r != 0)
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk_50m);
                    enable = 1'($urandom_range(0, 1));
                end
            enable = 1'b1;
            wait_quiet($sformatf("rnd%0d", r));
            check_exp($sformatf("rnd%0d", r), base);
            dfc = frame_cnt - fc0;
            check($sformatf("rnd%0d_fc_inc", r), dfc, n);
            check($sformatf("rnd%0d_err", r), err, 0);
        end

        check("wr_while_busy", viol_wr_busy, 0);
        check("rdreq_while_empty", viol_rd_empty, 0);
        check("rdreq_outside_idle", viol_rd_busy, 0);
        check("rdreq_multi_cycle", viol_rd_long, 0);
        check("b2b_opportunities", 32'(b2b_seen > 0), 1);
        check("b2b_late_rdreq", b2b_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_sched.md
UART_FRAME_SCHED -- requirements
Module: uart_frame_sched

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1024, clk_50m cycles allowed for tx_busy to rise after a write.
REQ-003 SHALL have port clk_50m  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  permits new frames to start.
REQ-006 SHALL have port fifo_empty  input  1  sample FIFO read-side empty flag.
REQ-007 SHALL have port fifo_q  input  16  FIFO read data, valid one cycle after fifo_rdreq.
REQ-008 SHALL have port fifo_rdreq  output  1  single-cycle FIFO read strobe.
REQ-009 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-010 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-011 SHALL have port tx_wr_en  output  1  single-cycle UART write strobe.
REQ-012 SHALL have port err_clr  input  1  clears err.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port frame_cnt  output  16  count of completed frames.
REQ-015 SHALL have port err  output  1  sticky transmitter-timeout flag.

Function
REQ-016 SHALL send each FIFO word as a 4-byte frame: HEADER, word[15:8], word[7:0], checksum = HEADER ^ word[15:8] ^ word[7:0].
REQ-017 SHALL implement states IDLE, RD, SEND, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE: when enable=1 and fifo_empty=0, SHALL assert fifo_rdreq for exactly one cycle and go to RD; otherwise stay in IDLE.
REQ-019 RD: SHALL capture fifo_q into the word register, clear byte index to 0, go to SEND.
REQ-020 SEND: when tx_busy=0, SHALL drive tx_data with the indexed byte, assert tx_wr_en one cycle, go to WAIT_ACK; while tx_busy=1, SHALL hold in SEND with tx_wr_en=0.
REQ-021 tx_data SHALL remain stable from the tx_wr_en cycle until leaving WAIT_DONE.
REQ-022 WAIT_ACK: on tx_busy=1 SHALL go to WAIT_DONE; a cycle counter SHALL start at 0 on entry and, on reaching ACK_TIMEOUT-1 without tx_busy=1, SHALL set err, abandon the frame, not increment frame_cnt, and return to IDLE.
REQ-023 WAIT_DONE: on tx_busy=0, SHALL increment byte index; index 3 complete -> frame_cnt+1 and go to IDLE; otherwise go to SEND.
REQ-024 frame_cnt SHALL wrap 16'hFFFF -> 16'h0000.
REQ-025 enable deasserted mid-frame SHALL NOT abort the frame; only new frames are gated.
REQ-026 fifo_rdreq SHALL never assert while fifo_empty=1 or outside IDLE; one read per frame.
REQ-027 err_clr SHALL clear err; simultaneous err_clr and timeout SHALL leave err=1.
REQ-028 Back-to-back frames: IDLE SHALL issue the next fifo_rdreq in the cycle after returning to IDLE if conditions hold.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, fifo_rdreq=0, tx_wr_en=0, tx_data=8'h00, busy=0, frame_cnt=0, err=0, byte index and timeout counter 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; after release the next frame SHALL start with HEADER and the next FIFO word.

Verification
REQ-031 fifo_q=16'h1234, one word, UART model busy 10 cycles per byte -> tx bytes A5,12,34,83; frame_cnt=1; fifo_rdreq pulsed once.
REQ-032 FIFO holds 3 words, enable=1 -> 12 bytes in order, frame_cnt=3, no tx_wr_en while tx_busy=1.
REQ-033 tx_busy never rises after write, ACK_TIMEOUT=16 -> err=1 on 16th WAIT_ACK cycle, frame_cnt unchanged, busy=0; err_clr pulse -> err=0.
REQ-034 enable dropped after second byte -> frame completes (4 bytes), no further fifo_rdreq while enable=0.
REQ-035 rst_n pulsed low during WAIT_DONE of byte 2 -> outputs at reset values asynchronously; next frame begins with A5.
REQ-036 frame_cnt preloaded via 65535 frames (or forced) -> next completed frame gives frame_cnt=0.
